// File: rtl/johnson_slot_arbiter.sv
// Time-division arbiter: a 4-bit Johnson counter walks 8 slots, and SLOT_MAP assigns each slot to one of 4 requesters.
// Define WORK_CONSERVE_EN to hand an idle owner's slot to the lowest-index active requester.
module johnson_slot_arbiter #(
   parameter logic [15:0] SLOT_MAP = 16'hE4E4,
   parameter int          HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic       grant_valid,
   output logic [1:0] grant_id,
   output logic [3:0] jc_state,
   output logic [2:0] slot_idx,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

   state_t          state, state_nxt;
   logic [3:0]      jc_nxt, jc_step;
   logic [3:0]      hold_cnt, hold_nxt;
   logic [3:0]      grant_nxt;
   logic [1:0]      gid_nxt;
   logic            gv_nxt, to_nxt;
   logic            jc_legal;
   logic [2:0]      slot_nxt;
   logic [7:0][1:0] slot_owner;
   logic [1:0]      owner, pick;
   logic            pick_ok, hold_hit, grant_end;

   // {legal, slot}; illegal codes decode to slot 0
   function automatic logic [3:0] jc_decode(input logic [3:0] jc);
      case (jc)
         4'b0000: jc_decode = 4'b1000;
         4'b0001: jc_decode = 4'b1001;
         4'b0011: jc_decode = 4'b1010;
         4'b0111: jc_decode = 4'b1011;
         4'b1111: jc_decode = 4'b1100;
         4'b1110: jc_decode = 4'b1101;
         4'b1100: jc_decode = 4'b1110;
         4'b1000: jc_decode = 4'b1111;
         default: jc_decode = 4'b0000;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_slot
         assign slot_owner[gi] = SLOT_MAP[2*gi +: 2];
      end
   endgenerate

   assign jc_legal  = jc_decode(jc_state)[3];
   assign jc_step   = {jc_state[2:0], ~jc_state[3]};
   assign owner     = slot_owner[slot_idx];
   assign hold_hit  = (hold_cnt == 4'(HOLD_MAX - 1));
   assign grant_end = done[grant_id] | ~req[grant_id] | hold_hit;
   assign slot_nxt  = jc_decode(jc_nxt)[2:0];

`ifdef WORK_CONSERVE_EN
   always_comb begin
      pick    = owner;
      pick_ok = req[owner];
      if (!req[owner] && (|req)) begin
         pick_ok = 1'b1;
         for (int i = 3; i >= 0; i--)
            if (req[i]) pick = 2'(i);
      end
   end
`else
   assign pick    = owner;
   assign pick_ok = req[owner];
`endif

   always_comb begin
      state_nxt = state;
      jc_nxt    = jc_state;
      hold_nxt  = hold_cnt;
      grant_nxt = grant;
      gid_nxt   = grant_id;
      gv_nxt    = grant_valid;
      to_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_nxt = SCAN;
         end
         SCAN: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (pick_ok) begin
               // jc stays on this slot until the grant ends
               state_nxt = GRANT;
               grant_nxt = 4'b0001 << pick;
               gid_nxt   = pick;
               gv_nxt    = 1'b1;
               hold_nxt  = 4'd0;
            end else begin
               jc_nxt = jc_step;
            end
         end
         GRANT: begin
            if (grant_end) begin
               state_nxt = enable ? SCAN : IDLE;
               grant_nxt = 4'd0;
               gid_nxt   = 2'd0;
               gv_nxt    = 1'b0;
               jc_nxt    = jc_step;
               to_nxt    = hold_hit & ~done[grant_id];
            end else begin
               hold_nxt = hold_cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!jc_legal) jc_nxt = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         jc_state    <= 4'd0;
         slot_idx    <= 3'd0;
         hold_cnt    <= 4'd0;
         grant       <= 4'd0;
         grant_id    <= 2'd0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         jc_state    <= jc_nxt;
         slot_idx    <= slot_nxt;
         hold_cnt    <= hold_nxt;
         grant       <= grant_nxt;
         grant_id    <= gid_nxt;
         grant_valid <= gv_nxt;
         timeout     <= to_nxt;
      end
   end

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
// Directed bench for johnson_slot_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_johnson_slot_arbiter;

   logic       clk, reset, enable;
   logic [3:0] req, done, grant, jc_state;
   logic       grant_valid, timeout;
   logic [1:0] grant_id;
   logic [2:0] slot_idx;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] rot_jc [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

   johnson_slot_arbiter #(.SLOT_MAP(16'hE4E4), .HOLD_MAX(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .req(req), .done(done),
      .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
      .jc_state(jc_state), .slot_idx(slot_idx), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock; invariants hold after every edge
   task automatic step();
      @(negedge clk);
      chk("onehot", 32'($onehot0(grant)), 32'd1);
      chk("gv_or", 32'(grant_valid), 32'(|grant));
   endtask

   task automatic reset_seq();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; req = 4'd0; done = 4'd0;
      step(); step();
      chk("rst_grant", grant, 0);
      chk("rst_gv", grant_valid, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_jc", jc_state, 0);
      chk("rst_slot", slot_idx, 0);
      chk("rst_to", timeout, 0);

      // full idle rotation
      reset = 1'b0; enable = 1'b1;
      step();
      chk("rot_enter", jc_state, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rot_jc", jc_state, rot_jc[i]);
         chk("rot_slot", slot_idx, 32'((i + 1) % 8));
         chk("rot_grant", grant, 0);
      end

      // single grant to requester 2, ended by done
      reset_seq();
      step(); step(); step();
      chk("sg_pre_jc", jc_state, 4'h3);
      chk("sg_pre_grant", grant, 0);
      req = 4'b0100;
      step();
      chk("sg_grant", grant, 4'b0100);
      chk("sg_gid", grant_id, 2);
      chk("sg_jc_hold", jc_state, 4'h3);
      step();
      done = 4'b0001;
      step();
      chk("sg_nonowner_done", grant, 4'b0100);
      chk("sg_jc_hold2", jc_state, 4'h3);
      done = 4'b0100;
      step();
      chk("sg_clear", grant, 0);
      chk("sg_gid_clr", grant_id, 0);
      chk("sg_jc_adv", jc_state, 4'h7);
      chk("sg_no_to", timeout, 0);
      done = 4'd0; req = 4'd0;

      // hold limit on requester 1
      reset_seq();
      step(); step();
      chk("to_pre_jc", jc_state, 4'h1);
      req = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("to_grant", grant, 4'b0010);
         chk("to_quiet", timeout, 0);
      end
      step();
      chk("to_clear", grant, 0);
      chk("to_pulse", timeout, 1);
      chk("to_jc", jc_state, 4'h3);
      req = 4'd0;
      step();
      chk("to_one_cycle", timeout, 0);

      // enable drops mid-grant to requester 3
      reset_seq();
      step(); step(); step(); step();
      chk("en_pre_jc", jc_state, 4'h7);
      req = 4'b1000;
      step();
      chk("en_grant", grant, 4'b1000);
      chk("en_gid", grant_id, 3);
      enable = 1'b0;
      step();
      chk("en_keep", grant, 4'b1000);
      done = 4'b1000;
      step();
      chk("en_clear", grant, 0);
      chk("en_jc", jc_state, 4'hF);
      done = 4'd0; req = 4'd0;
      step(); step();
      chk("en_frozen", jc_state, 4'hF);

      // illegal code recovery
      force dut.jc_state = 4'b0101;
      step();
      release dut.jc_state;
      step();
      chk("ill_jc", jc_state, 0);
      chk("ill_slot", slot_idx, 0);
      step();
      chk("ill_stay", jc_state, 0);
      enable = 1'b1;
      step();
      chk("ill_r0", jc_state, 4'h0);
      step();
      chk("ill_r1", jc_state, 4'h1);
      step();
      chk("ill_r3", jc_state, 4'h3);

      // reset mid-grant
      reset_seq();
      step();
      req = 4'b0001;
      step();
      chk("rg_grant", grant, 4'b0001);
      step();
      chk("rg_grant2", grant, 4'b0001);
      reset = 1'b1;
      step();
      chk("rg_grant0", grant, 0);
      chk("rg_gv0", grant_valid, 0);
      chk("rg_jc0", jc_state, 0);
      reset = 1'b0; req = 4'd0;
      step();
      chk("rg_idle", jc_state, 0);
      step();
      chk("rg_scan", jc_state, 4'h1);

      // requester 3 requesting from slot 0
      reset_seq();
      req = 4'b1000;
      step();
      chk("wc_enter", grant, 0);
`ifdef WORK_CONSERVE_EN
      step();
      chk("wc_grant", grant, 4'b1000);
      chk("wc_gid", grant_id, 3);
      chk("wc_jc", jc_state, 4'h0);
      step(); step(); step();
      step();
      chk("wc_clear", grant, 0);
      chk("wc_to", timeout, 1);
      chk("wc_jc_adv", jc_state, 4'h1);
`else
      step();
      chk("tdm_s1", grant, 0);
      chk("tdm_jc1", jc_state, 4'h1);
      step();
      chk("tdm_s2", grant, 0);
      step();
      chk("tdm_s3", grant, 0);
      chk("tdm_jc7", jc_state, 4'h7);
      step();
      chk("tdm_grant", grant, 4'b1000);
      chk("tdm_jc", jc_state, 4'h7);
`endif
      req = 4'd0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
